lcv_dot_seq: RTL

LCV_DOT_SEQ -- requirements
Module: lcv_dot_seq

---
 rtl/lcv_dot_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/lcv_dot_seq.sv
// Sequential dot-product controller driving an external 1-cycle MAC.
// Streams signed 16-bit operand pairs and emits a 33-bit wrapped sum with a term count.
module lcv_dot_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [32:0] mac_c,
    input  logic [32:0] mac_outp,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [32:0] res_data,
    output logic [15:0] res_cnt
);

    typedef enum logic [1:0] {
        ACC_FIRST,
        ACC,
        DRAIN,
        OUT
    } state_t;

    state_t      state;
    logic        issued_q;
    logic [32:0] acc_q;
    logic [15:0] cnt_q;
    logic        accept;

    assign in_ready = !rst && (state == ACC_FIRST || state == ACC);
    assign accept   = in_valid && in_ready;

    // Running sum lives in mac_outp right after an issue, else in acc_q.
    always_comb begin
        mac_a = 16'd0;
        mac_b = 16'd0;
        mac_c = 33'd0;
        if (accept) begin
            mac_a = in_a;
            mac_b = in_b;
            if (state == ACC)
                mac_c = issued_q ? mac_outp : acc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC_FIRST;
            issued_q  <= 1'b0;
            acc_q     <= 33'd0;
            cnt_q     <= 16'd0;
            res_valid <= 1'b0;
            res_data  <= 33'd0;
            res_cnt   <= 16'd0;
        end else begin
            issued_q <= accept;
            if (issued_q)
                acc_q <= mac_outp;
            unique case (state)
                ACC_FIRST, ACC: begin
                    if (accept) begin
                        if (state == ACC_FIRST)
                            cnt_q <= 16'd1;
                        else if (cnt_q != 16'hFFFF)
                            cnt_q <= cnt_q + 16'd1;
                        state <= in_last ? DRAIN : ACC;
                    end
                end
                DRAIN: begin
                    res_data  <= mac_outp;
                    res_cnt   <= cnt_q;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ACC_FIRST;
                    end
                end
                default: state <= ACC_FIRST;
            endcase
        end
    end

endmodule
